// File: rtl/pool_window_gen_pkg.sv
// pool_window_gen_pkg: shared CNN datapath widths and pooling frame defaults.
package pool_window_gen_pkg;
    localparam int DATA_WIDTH      = 8;
    localparam int POOL_IMG_WIDTH  = 28;
    localparam int POOL_IMG_HEIGHT = 28;
endpackage

// File: rtl/pool_window_gen_line_buffer.sv
// pool_line_buffer: one-row register array with a single write port and
// two combinational reads at the current column and its even partner.
module pool_line_buffer
    import pool_window_gen_pkg::*;
#(
    parameter int DEPTH = POOL_IMG_WIDTH,
    parameter int AW    = $clog2(POOL_IMG_WIDTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_prev_o,
    output logic [DATA_WIDTH-1:0] rdata_cur_o
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk)
        if (we_i) mem_q[waddr_i] <= wdata_i;

    // Only consumed at odd columns, where clearing bit 0 equals col-1 and stays in range.
    assign rdata_prev_o = mem_q[raddr_i & ~AW'(1)];
    assign rdata_cur_o  = mem_q[raddr_i];
endmodule

// File: rtl/pool_window_gen.sv
// pool_window_gen: turns a raster pixel stream into non-overlapping 2x2
// stride-2 windows with valid/ready handshakes on both sides.
module pool_window_gen
    import pool_window_gen_pkg::*;
#(
    parameter int IMG_WIDTH  = POOL_IMG_WIDTH,
    parameter int IMG_HEIGHT = POOL_IMG_HEIGHT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_pixel,
    output logic                  win_valid,
    input  logic                  win_ready,
    output logic [DATA_WIDTH-1:0] win_p1,
    output logic [DATA_WIDTH-1:0] win_p2,
    output logic [DATA_WIDTH-1:0] win_p3,
    output logic [DATA_WIDTH-1:0] win_p4,
    output logic                  win_last
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [DATA_WIDTH-1:0] hold_q, lb_prev, lb_cur;
    logic                  accept, load, col_end, row_end;

    assign in_ready = ~win_valid | win_ready;
    assign accept   = in_valid & in_ready;
    assign col_end  = col_q == CW'(IMG_WIDTH - 1);
    assign row_end  = row_q == RW'(IMG_HEIGHT - 1);
    assign load     = accept & row_q[0] & col_q[0];

    always_comb begin
        col_d = accept ? (col_end ? '0 : col_q + 1'b1) : col_q;
        row_d = (accept & col_end) ? (row_end ? '0 : row_q + 1'b1) : row_q;
    end

    pool_line_buffer #(.DEPTH(IMG_WIDTH), .AW(CW)) u_line_buf (
        .clk          (clk),
        .we_i         (accept & ~row_q[0]),
        .waddr_i      (col_q),
        .wdata_i      (in_pixel),
        .raddr_i      (col_q),
        .rdata_prev_o (lb_prev),
        .rdata_cur_o  (lb_cur)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q     <= '0;
            row_q     <= '0;
            hold_q    <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            win_p1    <= '0;
            win_p2    <= '0;
            win_p3    <= '0;
            win_p4    <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            if (accept & row_q[0] & ~col_q[0]) hold_q <= in_pixel;
            if (load) begin
                win_p1    <= lb_prev;
                win_p2    <= lb_cur;
                win_p3    <= hold_q;
                win_p4    <= in_pixel;
                win_last  <= row_end & col_end;
                win_valid <= 1'b1;
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pool_window_gen.sv
// tb_pool_window_gen: scoreboard bench for a 4x4 directed instance and a 28x28 randomised instance.
module tb_pool_window_gen;
    import pool_window_gen_pkg::*;

    typedef struct {
        logic [7:0] p1, p2, p3, p4;
        logic       last;
        logic [7:0] mx;
    } win_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4_n = 1'b1, iv4 = 1'b0, wr4 = 1'b1, ir4, wv4, wl4;
    logic [7:0] px4 = '0, a4, b4, c4, d4;
    logic       rst28_n = 1'b1, iv28 = 1'b0, wr28 = 1'b0, ir28, wv28, wl28;
    logic [7:0] px28 = '0, a28, b28, c28, d28;

    int   n_cmp = 0, n_fail = 0, n28 = 0;
    bit   drv28_done = 1'b0;
    win_t q4[$], q28[$];
    logic [7:0] img[784];

    pool_window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
        .clk(clk), .reset_n(rst4_n), .in_valid(iv4), .in_ready(ir4), .in_pixel(px4),
        .win_valid(wv4), .win_ready(wr4), .win_p1(a4), .win_p2(b4), .win_p3(c4),
        .win_p4(d4), .win_last(wl4));

    pool_window_gen #(.IMG_WIDTH(28), .IMG_HEIGHT(28)) dut28 (
        .clk(clk), .reset_n(rst28_n), .in_valid(iv28), .in_ready(ir28), .in_pixel(px28),
        .win_valid(wv28), .win_ready(wr28), .win_p1(a28), .win_p2(b28), .win_p3(c28),
        .win_p4(d28), .win_last(wl28));

    function automatic logic [7:0] max4(input logic [7:0] a, b, c, d);
        logic [7:0] m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic exp4(input logic [7:0] p1, p2, p3, p4, input logic last, input logic [7:0] mx);
        win_t w;
        w.p1 = p1; w.p2 = p2; w.p3 = p3; w.p4 = p4; w.last = last; w.mx = mx;
        q4.push_back(w);
    endtask

    task automatic exp_ascending(input int b);
        exp4(8'(b+0),  8'(b+1),  8'(b+4),  8'(b+5),  1'b0, 8'(b+5));
        exp4(8'(b+2),  8'(b+3),  8'(b+6),  8'(b+7),  1'b0, 8'(b+7));
        exp4(8'(b+8),  8'(b+9),  8'(b+12), 8'(b+13), 1'b0, 8'(b+13));
        exp4(8'(b+10), 8'(b+11), 8'(b+14), 8'(b+15), 1'b1, 8'(b+15));
    endtask

    task automatic push4(input logic [7:0] px, input bit lat, input logic exp_v);
        int  n;
        bit  acc;
        iv4 = 1'b1;
        px4 = px;
        n   = 0;
        do begin
            @(negedge clk);
            acc = ir4;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        iv4 = 1'b0;
        if (!acc) chk("push4 timeout", 32'(px), 32'hFFFF);
        if (lat) chk("win_valid after accept", 32'(wv4), 32'(exp_v));
    endtask

    task automatic frame4(input int base, input bit desc, input bit lat);
        for (int k = 0; k < 16; k++)
            push4(desc ? 8'(255 - k) : 8'(base + k), lat, ((k / 4) % 2 == 1) && ((k % 4) % 2 == 1));
    endtask

    task automatic push28(input logic [7:0] px);
        int n;
        bit acc;
        iv28 = 1'b1;
        px28 = px;
        n    = 0;
        do begin
            @(negedge clk);
            acc = ir28;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        iv28 = 1'b0;
        if (!acc) chk("push28 timeout", 32'(px), 32'hFFFF);
    endtask

    always @(negedge clk) begin : mon4
        win_t e;
        if (rst4_n && wv4 && wr4) begin
            n_cmp++;
            if (q4.size() == 0) begin
                n_fail++;
                $display("FAIL win4: unexpected window %0d %0d %0d %0d last=%0d", a4, b4, c4, d4, wl4);
            end else begin
                e = q4.pop_front();
                if (a4 !== e.p1 || b4 !== e.p2 || c4 !== e.p3 || d4 !== e.p4 || wl4 !== e.last ||
                    max4(a4, b4, c4, d4) !== e.mx) begin
                    n_fail++;
                    $display("FAIL win4: got %0d %0d %0d %0d last=%0d max=%0d expected %0d %0d %0d %0d last=%0d max=%0d",
                             a4, b4, c4, d4, wl4, max4(a4, b4, c4, d4), e.p1, e.p2, e.p3, e.p4, e.last, e.mx);
                end
            end
        end
    end

    always @(negedge clk) begin : mon28
        win_t e;
        if (rst28_n && wv28 && wr28) begin
            n_cmp++;
            n28++;
            if (q28.size() == 0) begin
                n_fail++;
                $display("FAIL win28: unexpected window %0d %0d %0d %0d", a28, b28, c28, d28);
            end else begin
                e = q28.pop_front();
                if (a28 !== e.p1 || b28 !== e.p2 || c28 !== e.p3 || d28 !== e.p4 || wl28 !== e.last) begin
                    n_fail++;
                    $display("FAIL win28: got %0d %0d %0d %0d last=%0d expected %0d %0d %0d %0d last=%0d",
                             a28, b28, c28, d28, wl28, e.p1, e.p2, e.p3, e.p4, e.last);
                end
            end
        end
    end

    initial begin : ready28
        forever begin
            @(posedge clk);
            #1;
            wr28 = drv28_done ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    initial begin : drive28
        win_t w;
        wait (rst28_n === 1'b0);
        wait (rst28_n === 1'b1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 784; i++) img[i] = 8'($urandom_range(0, 255));
        for (int r = 0; r < 14; r++)
            for (int c = 0; c < 14; c++) begin
                w.p1 = img[(2*r)*28 + 2*c];
                w.p2 = img[(2*r)*28 + 2*c + 1];
                w.p3 = img[(2*r+1)*28 + 2*c];
                w.p4 = img[(2*r+1)*28 + 2*c + 1];
                w.last = (r == 13) && (c == 13);
                w.mx = max4(w.p1, w.p2, w.p3, w.p4);
                q28.push_back(w);
            end
        for (int i = 0; i < 784; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                iv28 = 1'b0;
                @(posedge clk);
                #1;
            end
            push28(img[i]);
        end
        drv28_done = 1'b1;
    end

    initial begin : main
        int n;
        #3;
        rst4_n  = 1'b0;
        rst28_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset win_valid", 32'(wv4), 32'd0);
        chk("reset win_last", 32'(wl4), 32'd0);
        chk("reset win_p1..p4", {a4, b4, c4, d4}, 32'd0);
        chk("reset in_ready", 32'(ir4), 32'd1);
        rst4_n  = 1'b1;
        rst28_n = 1'b1;
        @(posedge clk);
        #1;

        exp_ascending(0);
        frame4(0, 1'b0, 1'b1);

        exp4(255, 254, 251, 250, 1'b0, 255);
        exp4(253, 252, 249, 248, 1'b0, 253);
        exp4(247, 246, 243, 242, 1'b0, 247);
        exp4(245, 244, 241, 240, 1'b1, 245);
        frame4(0, 1'b1, 1'b1);

        exp_ascending(0);
        for (int k = 0; k < 5; k++) push4(8'(k), 1'b0, 1'b0);
        wr4 = 1'b0;
        push4(8'd5, 1'b1, 1'b1);
        fork
            push4(8'd6, 1'b1, 1'b0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("stall in_ready", 32'(ir4), 32'd0);
                    chk("stall win_valid", 32'(wv4), 32'd1);
                    chk("stall window", {a4, b4, c4, d4}, {8'd0, 8'd1, 8'd4, 8'd5});
                    @(posedge clk);
                    #1;
                end
                wr4 = 1'b1;
            end
        join
        for (int k = 7; k < 16; k++) push4(8'(k), 1'b1, ((k / 4) % 2 == 1) && ((k % 4) % 2 == 1));

        exp4(0, 1, 4, 5, 1'b0, 5);
        for (int k = 0; k < 7; k++) push4(8'(k), 1'b0, 1'b0);
        #2;
        rst4_n = 1'b0;
        #1;
        chk("async reset win_p1..p4", {a4, b4, c4, d4}, 32'd0);
        chk("async reset win_valid", 32'(wv4), 32'd0);
        @(posedge clk);
        #1;
        rst4_n = 1'b1;
        exp_ascending(0);
        frame4(0, 1'b0, 1'b1);

        exp_ascending(0);
        exp_ascending(100);
        frame4(0, 1'b0, 1'b1);
        frame4(100, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("q4 drained", 32'(q4.size()), 32'd0);

        n = 0;
        while (n28 < 196 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("win28 count", 32'(n28), 32'd196);
        chk("q28 drained", 32'(q28.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
